// File: rtl/adc_if_pkg.sv
// Shared register map, AXI response codes and STATUS layout for the ADC_IF
// AXI4-Lite register block.
package adc_if_pkg;

    localparam logic [2:0] REG0_IDX   = 3'd0;
    localparam logic [2:0] REG1_IDX   = 3'd1;
    localparam logic [2:0] REG2_IDX   = 3'd2;
    localparam logic [2:0] REG3_IDX   = 3'd3;
    localparam logic [2:0] STATUS_IDX = 3'd4;
    localparam logic [2:0] SAMPLE_IDX = 3'd5;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int unsigned STATUS_UNREAD_BIT  = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;
    localparam int unsigned STATUS_CNT_LSB     = 16;
    localparam int unsigned SAMPLE_CNT_W       = 16;

    // RW registers accept writes; the RO status/sample slots reject them.
    function automatic axi_resp_e wr_resp(input logic [2:0] idx);
        if (idx <= REG3_IDX)        return RESP_OKAY;
        else if (idx <= SAMPLE_IDX) return RESP_SLVERR;
        else                        return RESP_DECERR;
    endfunction

    function automatic axi_resp_e rd_resp(input logic [2:0] idx);
        return (idx <= SAMPLE_IDX) ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/adc_if_sample_capture.sv
// Latches the most recent ADC sample and tracks unread/overrun flags plus a
// wrapping sample counter; a clear from a SAMPLE read drops both flags.
module adc_if_sample_capture
    import adc_if_pkg::*;
#(
    parameter int unsigned C_SAMPLE_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [C_SAMPLE_WIDTH-1:0] i_sample,
    input  logic                      i_valid,
    input  logic                      i_clear,
    output logic [C_SAMPLE_WIDTH-1:0] o_sample,
    output logic                      o_unread,
    output logic                      o_overrun,
    output logic [SAMPLE_CNT_W-1:0]   o_cnt
);

    logic [C_SAMPLE_WIDTH-1:0] r_sample;
    logic                      r_unread;
    logic                      r_overrun;
    logic [SAMPLE_CNT_W-1:0]   r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample  <= '0;
            r_unread  <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else if (i_valid) begin
            r_sample  <= i_sample;
            r_cnt     <= r_cnt + 1'b1;
            r_unread  <= 1'b1;
            // A simultaneous read consumed the old sample, so no overrun.
            r_overrun <= i_clear ? 1'b0 : (r_overrun | r_unread);
        end else if (i_clear) begin
            r_unread  <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_sample  = r_sample;
    assign o_unread  = r_unread;
    assign o_overrun = r_overrun;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/adc_if_axil_regs.sv
// AXI4-Lite slave holding four RW control registers for the ADC_IF datapath
// and read-only STATUS/SAMPLE views of the latest captured ADC sample.
module adc_if_axil_regs
    import adc_if_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_SAMPLE_WIDTH     = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    input  logic [C_SAMPLE_WIDTH-1:0]       adc_sample_i,
    input  logic                            adc_valid_i
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;

    logic [DW-1:0]             r_regs [4];
    logic                      r_awready, r_wready, r_aw_done, r_w_done;
    logic [2:0]                r_aw_idx;
    logic [DW-1:0]             r_wdata;
    logic [SW-1:0]             r_wstrb;
    logic                      r_bvalid, r_arready, r_rvalid;
    axi_resp_e                 r_bresp, r_rresp;
    logic [DW-1:0]             r_rdata;

    logic                      w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
    logic [2:0]                w_wr_idx, w_ar_idx;
    logic [DW-1:0]             w_wdata, w_wmask, w_merged, w_status, w_rd_word;
    logic [SW-1:0]             w_wstrb;
    logic [C_SAMPLE_WIDTH-1:0] w_sample;
    logic                      w_unread, w_overrun;
    logic [SAMPLE_CNT_W-1:0]   w_cnt;
    logic                      w_unused;

    assign w_aw_hs   = S_AXI_AWVALID & r_awready;
    assign w_w_hs    = S_AXI_WVALID & r_wready;
    assign w_ar_hs   = S_AXI_ARVALID & r_arready;
    // Address and data may each arrive live this cycle or from an earlier latch.
    assign w_wr_fire = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_wr_idx  = r_aw_done ? r_aw_idx : S_AXI_AWADDR[4:2];
    assign w_wdata   = r_w_done ? r_wdata : S_AXI_WDATA;
    assign w_wstrb   = r_w_done ? r_wstrb : S_AXI_WSTRB;
    assign w_ar_idx  = S_AXI_ARADDR[4:2];

    for (genvar g = 0; g < SW; g++) begin : g_mask
        assign w_wmask[8*g +: 8] = {8{w_wstrb[g]}};
    end
    assign w_merged = (r_regs[w_wr_idx[1:0]] & ~w_wmask) | (w_wdata & w_wmask);

    always_comb begin
        w_status = '0;
        w_status[STATUS_UNREAD_BIT]                  = w_unread;
        w_status[STATUS_OVERRUN_BIT]                 = w_overrun;
        w_status[STATUS_CNT_LSB +: SAMPLE_CNT_W]     = w_cnt;
        w_rd_word = '0;
        if (w_ar_idx <= REG3_IDX)         w_rd_word = r_regs[w_ar_idx[1:0]];
        else if (w_ar_idx == STATUS_IDX)  w_rd_word = w_status;
        else if (w_ar_idx == SAMPLE_IDX)  w_rd_word = DW'(w_sample);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_regs    <= '{default: '0};
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_awready <= 1'b0;
                r_aw_done <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[4:2];
            end
            if (w_w_hs) begin
                r_wready <= 1'b0;
                r_w_done <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_wr_fire) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= wr_resp(w_wr_idx);
                if (w_wr_idx <= REG3_IDX) r_regs[w_wr_idx[1:0]] <= w_merged;
            end
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= rd_resp(w_ar_idx);
            r_rdata   <= w_rd_word;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    adc_if_sample_capture #(
        .C_SAMPLE_WIDTH(C_SAMPLE_WIDTH)
    ) u_capture (
        .i_clk    (ACLK),
        .i_rst    (ARESET),
        .i_sample (adc_sample_i),
        .i_valid  (adc_valid_i),
        .i_clear  (w_ar_hs && (w_ar_idx == SAMPLE_IDX)),
        .o_sample (w_sample),
        .o_unread (w_unread),
        .o_overrun(w_overrun),
        .o_cnt    (w_cnt)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign reg0_o        = r_regs[0];
    assign reg1_o        = r_regs[1];
    assign reg2_o        = r_regs[2];
    assign reg3_o        = r_regs[3];

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_adc_if_axil_regs.sv
// Randomised self-checking bench for adc_if_axil_regs against a register-map
// level model of the control registers and the sample/status state.
module tb_adc_if_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
    logic [15:0] adc_sample_i = '0;
    logic        adc_valid_i = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [4];
    logic [15:0] m_sample, m_cnt;
    bit          m_unread, m_over;

    adc_if_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .C_SAMPLE_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .adc_sample_i(adc_sample_i), .adc_valid_i(adc_valid_i)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return m_regs[a[3:2]];
            3'd4:    return {m_cnt, 14'd0, m_over, m_unread};
            3'd5:    return {16'd0, m_sample};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [4:0] a);
        return (a[4:2] > 3'd5) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [4:0] a);
        if (a[4:2] < 3'd4) return 2'b00;
        if (a[4:2] < 3'd6) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [31:0] dut_reg(input int i);
        case (i)
            0:       return reg0_o;
            1:       return reg1_o;
            2:       return reg2_o;
            default: return reg3_o;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
        m_sample = 16'd0; m_cnt = 16'd0; m_unread = 0; m_over = 0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (a[4:2] < 3'd4) m_regs[a[3:2]] = (m_regs[a[3:2]] & ~mask) | (d & mask);
    endtask

    task automatic model_read(input logic [4:0] a);
        if (a[4:2] == 3'd5) begin m_unread = 0; m_over = 0; end
    endtask

    task automatic model_pulse(input logic [15:0] s, input bit with_sample_read);
        if (m_unread) m_over = 1;
        m_unread = 1;
        m_sample = s;
        m_cnt = m_cnt + 16'd1;
        if (with_sample_read) m_over = 0;
    endtask

    // ---------------- bus drivers ----------------
    task automatic do_reset();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        S_AXI_BREADY = 0; S_AXI_RREADY = 0; adc_valid_i = 0;
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        model_reset();
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_pend = 1, w_pend = 1, aw_ok, w_ok;
        int n = 0;
        resp = 2'bxx;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_ok = aw_pend && S_AXI_AWREADY;
            w_ok  = w_pend && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_ok) begin aw_pend = 0; S_AXI_AWVALID = 0; end
            if (w_ok)  begin w_pend = 0;  S_AXI_WVALID = 0;  end
            n++;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        S_AXI_BREADY = 1; n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_BVALID) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%h: bvalid got 0 want 1", a);
        end else begin
            resp = S_AXI_BRESP;
        end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        int n = 0;
        d = 'x; resp = 'x;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        while (!ok && n < 20) begin
            ok = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        S_AXI_ARVALID = 0;
        S_AXI_RREADY = 1; n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_RVALID) begin
            total++; bad++;
            $display("FAIL read_timeout addr=%h: rvalid got 0 want 1", a);
        end else begin
            d = S_AXI_RDATA; resp = S_AXI_RRESP;
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 0;
    endtask

    task automatic pulse_sample(input logic [15:0] s);
        adc_sample_i = s; adc_valid_i = 1;
        @(posedge ACLK); #1;
        adc_valid_i = 0;
        model_pulse(s, 0);
    endtask

    // Read with full model comparison of data and response.
    task automatic check_read(input logic [4:0] a, input string name);
        logic [31:0] d, e;
        logic [1:0]  r, er;
        e = exp_rd(a); er = exp_rresp(a);
        axi_read(a, d, r);
        model_read(a);
        total++;
        if (d !== e) begin bad++; $display("FAIL %s rdata addr=%h got %h want %h", name, a, d, e); end
        total++;
        if (r !== er) begin bad++; $display("FAIL %s rresp addr=%h got %b want %b", name, a, r, er); end
    endtask

    task automatic check_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                               input string name);
        logic [1:0] r, er;
        er = exp_bresp(a);
        axi_write(a, d, s, r);
        model_write(a, d, s);
        total++;
        if (r !== er) begin bad++; $display("FAIL %s bresp addr=%h got %b want %b", name, a, r, er); end
    endtask

    task automatic check_reg_outputs(input string name);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dut_reg(i) !== m_regs[i]) begin
                bad++;
                $display("FAIL %s reg%0d_o got %h want %h", name, i, dut_reg(i), m_regs[i]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            bad++; $display("FAIL reset_ready got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        total++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP} !== 6'b0) begin
            bad++; $display("FAIL reset_resp got %b want 000000",
                            {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP});
        end
        total++;
        if (S_AXI_RDATA !== 32'd0) begin bad++; $display("FAIL reset_rdata got %h want 0", S_AXI_RDATA); end
        check_reg_outputs("reset");
        check_read(5'h10, "reset_status");
        check_read(5'h14, "reset_sample");
    endtask

    task automatic test_basic_rw();
        for (int i = 0; i < 4; i++) check_write(5'(4 * i), 32'(i + 1), 4'hF, "basic_wr");
        for (int i = 0; i < 4; i++) check_read(5'(4 * i), "basic_rd");
        check_reg_outputs("basic");
        total++;
        if (reg3_o !== 32'd4) begin bad++; $display("FAIL basic_reg3 got %h want 4", reg3_o); end
    endtask

    task automatic test_strobe();
        check_write(5'h04, 32'hAABBCCDD, 4'hF, "strb_full");
        check_write(5'h04, 32'h11223344, 4'b0101, "strb_part");
        check_read(5'h04, "strb_rd");
        total++;
        if (reg1_o !== 32'hAA22CC44) begin bad++; $display("FAIL strb_reg1 got %h want aa22cc44", reg1_o); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        d = $urandom;
        S_AXI_BREADY = 0;
        S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 0;
        total++;
        if (S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL wfirst_wready got %b want 0", S_AXI_WREADY); end
        repeat (2) begin
            total++;
            if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL wfirst_early_b got %b want 0", S_AXI_BVALID); end
            @(posedge ACLK); #1;
        end
        total++;
        if (S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL wfirst_awready got %b want 1", S_AXI_AWREADY); end
        S_AXI_AWADDR = 5'h0A; S_AXI_AWVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0;
        model_write(5'h0A, d, 4'hF);
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP} !== 5'b10000) begin
                bad++; $display("FAIL wfirst_hold cyc=%0d bvalid/awready/wready/bresp got %b want 10000",
                                c, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP});
            end
            if (c < 4) begin @(posedge ACLK); #1; end
        end
        S_AXI_BREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
        total++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            bad++; $display("FAIL wfirst_release got %b want 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        end
        check_read(5'h08, "wfirst_rd");
    endtask

    task automatic test_errors();
        check_write(5'h10, $urandom, 4'hF, "err_status_wr");
        check_write(5'h14, $urandom, 4'hF, "err_sample_wr");
        check_write(5'h1C, $urandom, 4'hF, "err_unmapped_wr");
        check_read(5'h10, "err_status_rd");
        check_read(5'h18, "err_unmapped_rd");
        check_read(5'h1F, "err_unmapped_rd2");
        check_reg_outputs("err");
    endtask

    task automatic test_sample();
        logic [31:0] d;
        logic [1:0]  r;
        do_reset();
        pulse_sample(16'h0123);
        pulse_sample(16'h0456);
        axi_read(5'h10, d, r);
        total++;
        if (d !== 32'h0002_0003) begin bad++; $display("FAIL sample_status got %h want 00020003", d); end
        axi_read(5'h14, d, r);
        model_read(5'h14);
        total++;
        if (d !== 32'h0000_0456) begin bad++; $display("FAIL sample_data got %h want 00000456", d); end
        axi_read(5'h10, d, r);
        total++;
        if (d !== 32'h0002_0000) begin bad++; $display("FAIL sample_cleared got %h want 00020000", d); end
    endtask

    task automatic test_sample_read_collision();
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        pulse_sample(16'h0456);
        S_AXI_ARADDR = 5'h14; S_AXI_ARVALID = 1;
        adc_sample_i = 16'h0789; adc_valid_i = 1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 0; adc_valid_i = 0;
        model_pulse(16'h0789, 1);
        S_AXI_RREADY = 1;
        while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        d = S_AXI_RDATA;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 0;
        total++;
        if (d !== 32'h0000_0456) begin bad++; $display("FAIL collide_rdata got %h want 00000456", d); end
        axi_read(5'h10, d, r);
        total++;
        if (d[1:0] !== 2'b01) begin bad++; $display("FAIL collide_flags got %b want 01", d[1:0]); end
        total++;
        if (d !== exp_rd(5'h10)) begin bad++; $display("FAIL collide_status got %h want %h", d, exp_rd(5'h10)); end
        check_read(5'h14, "collide_sample");
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] d_new, d_old, got;
        d_new = $urandom;
        d_old = m_regs[2];
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1;
        S_AXI_WDATA = d_new; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        model_write(5'h08, d_new, 4'hF);
        total++;
        if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
            bad++; $display("FAIL samecyc_valid got %b want 11", {S_AXI_BVALID, S_AXI_RVALID});
        end
        got = S_AXI_RDATA;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        total++;
        if (got !== d_old) begin bad++; $display("FAIL samecyc_old got %h want %h", got, d_old); end
        check_read(5'h08, "samecyc_new");
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int it = 0; it < 60; it++) begin
            a = 5'($urandom);
            case ($urandom_range(0, 2))
                0: check_write(a, $urandom, 4'($urandom), "rand_wr");
                1: check_read(a, "rand_rd");
                default: pulse_sample(16'($urandom));
            endcase
        end
        check_reg_outputs("rand");
    endtask

    task automatic test_cnt_wrap();
        logic [15:0] s;
        check_read(5'h14, "wrap_pre");
        adc_valid_i = 1;
        for (int i = 0; i < 65536; i++) begin
            s = 16'($urandom);
            adc_sample_i = s;
            @(posedge ACLK); #1;
            model_pulse(s, 0);
        end
        adc_valid_i = 0;
        check_read(5'h10, "wrap_status");
        check_read(5'h14, "wrap_sample");
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_strobe();
        test_w_before_aw();
        test_errors();
        test_sample();
        test_sample_read_collision();
        test_same_cycle_rw();
        test_random();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
